// File: rtl/pkt_pkg.sv
// Shared packet framing definitions: state encoding, default sync byte and frame overhead.
package pkt_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 8;
    localparam int unsigned MAX_LEN_DEF      = 8;
    localparam int unsigned IDLE_TIMEOUT_DEF = 16;
    localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;

    // SYNC + LEN + CSUM bytes surrounding the payload
    localparam int unsigned FRAME_OVERHEAD   = 3;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SEND_SYNC,
        SEND_LEN,
        SEND_PAY,
        SEND_CSUM
    } pkt_state_t;

endpackage

// File: rtl/pkt_framer_if.sv
// Fifo read side and framed tx stream of the packetizer, bundled as one port.
interface pkt_framer_if
    import pkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_sop;
    logic                  tx_eop;
    logic                  busy;

    // Framer side
    modport master (
        output fifo_rd_en,
        input  fifo_data_out,
        input  fifo_empty,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        output tx_sop,
        output tx_eop,
        output busy
    );

    // Fifo / transmitter side
    modport slave (
        input  fifo_rd_en,
        output fifo_data_out,
        output fifo_empty,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        input  tx_sop,
        input  tx_eop,
        input  busy
    );

endinterface

// File: rtl/pkt_payload_buf.sv
// Payload staging buffer: sequential writes from the fifo, random-access read for transmit.
module pkt_payload_buf
    import pkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
    parameter int unsigned IDX_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_LEN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      wr_idx;

    // Append captured bytes; pointer rewinds whenever the framer is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_idx <= '0;
        end else if (wr_en && (wr_idx < LAST)) begin
            mem[ADDR_W'(wr_idx)] <= wr_data;
            wr_idx               <= wr_idx + IDX_W'(1);
        end
    end

    // Out-of-range index (one past the last byte) reads as zero
    always_comb begin
        rd_data = '0;
        if (rd_idx < LAST) begin
            rd_data = mem[ADDR_W'(rd_idx)];
        end
    end

endmodule

// File: rtl/pkt_framer.sv
// Drains the byte fifo into a payload buffer and emits SYNC, LEN, payload, CSUM frames.
module pkt_framer
    import pkt_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned         MAX_LEN      = MAX_LEN_DEF,
    parameter int unsigned         IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(SYNC_BYTE_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    pkt_framer_if.master bus
);

    localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
    localparam int unsigned TO_W  = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_LEN);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(IDLE_TIMEOUT);

    pkt_state_t            state;
    logic [IDX_W-1:0]      issued;
    logic [IDX_W-1:0]      captured;
    logic [IDX_W-1:0]      idx;
    logic [TO_W-1:0]       empty_cnt;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] len;
    logic [DATA_WIDTH-1:0] csum;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_sop;
    logic                  tx_eop;
    logic                  busy;

    logic                  rd_en;
    logic                  timeout_hit;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    // Read strobe must drop in the same cycle the fifo reports empty, so it is combinational
    assign rd_en       = (state == COLLECT) && !bus.fifo_empty && (issued < MAX_IDX);
    assign timeout_hit = (empty_cnt == TO_MAX) && (captured != '0) && !rd_pending && !rd_en;
    // Prefetch the byte that follows the one currently presented
    assign rd_idx      = (state == SEND_PAY) ? idx + IDX_W'(1) : '0;

    assign bus.fifo_rd_en = rd_en;
    assign bus.tx_data    = tx_data;
    assign bus.tx_valid   = tx_valid;
    assign bus.tx_sop     = tx_sop;
    assign bus.tx_eop     = tx_eop;
    assign bus.busy       = busy;

    pkt_payload_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_LEN    (MAX_LEN),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .wr_en   (rd_pending),
        .wr_data (bus.fifo_data_out),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // Framing FSM with counters, checksum and registered tx outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issued     <= '0;
            captured   <= '0;
            idx        <= '0;
            empty_cnt  <= '0;
            rd_pending <= 1'b0;
            len        <= '0;
            csum       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_sop     <= 1'b0;
            tx_eop     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            case (state)
                IDLE: begin
                    if (!bus.fifo_empty) begin
                        state     <= COLLECT;
                        busy      <= 1'b1;
                        issued    <= '0;
                        captured  <= '0;
                        empty_cnt <= '0;
                        csum      <= '0;
                    end
                end
                COLLECT: begin
                    if (rd_en) begin
                        issued <= issued + IDX_W'(1);
                    end
                    if (rd_pending) begin
                        captured <= captured + IDX_W'(1);
                        csum     <= csum ^ bus.fifo_data_out;
                    end
                    if (rd_en || !bus.fifo_empty) begin
                        empty_cnt <= '0;
                    end else if (empty_cnt != TO_MAX) begin
                        empty_cnt <= empty_cnt + TO_W'(1);
                    end
                    // Both exits guarantee no capture is pending this cycle
                    if ((captured == MAX_IDX) || timeout_hit) begin
                        state    <= SEND_SYNC;
                        len      <= DATA_WIDTH'(captured);
                        csum     <= csum ^ DATA_WIDTH'(captured);
                        tx_valid <= 1'b1;
                        tx_data  <= SYNC_BYTE;
                        tx_sop   <= 1'b1;
                    end
                end
                SEND_SYNC: begin
                    if (bus.tx_ready) begin
                        state   <= SEND_LEN;
                        tx_data <= len;
                        tx_sop  <= 1'b0;
                    end
                end
                SEND_LEN: begin
                    if (bus.tx_ready) begin
                        state   <= SEND_PAY;
                        idx     <= '0;
                        tx_data <= rd_data;
                    end
                end
                SEND_PAY: begin
                    if (bus.tx_ready) begin
                        if (DATA_WIDTH'(idx) == len - DATA_WIDTH'(1)) begin
                            state   <= SEND_CSUM;
                            tx_data <= csum;
                            tx_eop  <= 1'b1;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            tx_data <= rd_data;
                        end
                    end
                end
                SEND_CSUM: begin
                    if (bus.tx_ready) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_eop   <= 1'b0;
                        tx_data  <= '0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer with a behavioural byte fifo and tx sink.
module tb_pkt_framer;
    import pkt_pkg::*;

    logic clk = 1'b0;
    logic rst;

    pkt_framer_if #(.DATA_WIDTH(8)) bus ();

    pkt_framer #(
        .DATA_WIDTH   (8),
        .MAX_LEN      (8),
        .IDLE_TIMEOUT (16),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [9:0] out_q[$];
    int         out_c[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         rdy_mode = 0;
    int         rd_empty_cnt = 0;
    bit         saw_rd, saw_valid, saw_busy;
    bit         prev_stall = 1'b0;
    bit         last_rst   = 1'b1;
    logic [9:0] prev_word;
    bit         rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs at negedge, update fifo and tx_ready just after posedge
    task automatic step();
        logic rd;
        @(negedge clk);
        if (prev_stall && !last_rst) begin
            chk("hold", 32'({bus.tx_valid, bus.tx_sop, bus.tx_eop, bus.tx_data}), 32'({1'b1, prev_word}));
        end
        if (bus.tx_valid && bus.tx_ready) begin
            out_q.push_back({bus.tx_sop, bus.tx_eop, bus.tx_data});
            out_c.push_back(cyc);
        end
        if (bus.fifo_rd_en && bus.fifo_empty) rd_empty_cnt++;
        if (bus.fifo_rd_en) saw_rd = 1'b1;
        if (bus.tx_valid)   saw_valid = 1'b1;
        if (bus.busy)       saw_busy = 1'b1;
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_word  = {bus.tx_sop, bus.tx_eop, bus.tx_data};
        rd = bus.fifo_rd_en;
        @(posedge clk);
        last_rst = rst;
        #1;
        cyc++;
        if (rd && fifo_q.size() > 0) bus.fifo_data_out = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.tx_ready   = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rdy_pat[cyc % 4] : 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        out_q.delete();
        out_c.delete();
    endtask

    task automatic push_bytes(input logic [7:0] b[$]);
        foreach (b[i]) fifo_q.push_back(b[i]);
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_count"}, 32'(out_q.size()), 32'(n));
    endtask

    task automatic pop_chk(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        got = (out_q.size() > 0) ? out_q.pop_front() : 10'h3FF;
        if (out_c.size() > 0) void'(out_c.pop_front());
        chk(tag, 32'(got), 32'(exp));
    endtask

    // Expected frame built from the payload: {sop, eop, byte}
    task automatic check_frame(input string tag, input logic [7:0] pay[$]);
        logic [7:0] cs;
        cs = 8'(pay.size());
        foreach (pay[i]) cs = cs ^ pay[i];
        pop_chk({tag, "_sync"}, {2'b10, 8'hA5});
        pop_chk({tag, "_len"},  {2'b00, 8'(pay.size())});
        foreach (pay[i]) pop_chk($sformatf("%s_pay%0d", tag, i), {2'b00, pay[i]});
        pop_chk({tag, "_csum"}, {2'b01, cs});
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] p2[$];
        rst               = 1'b1;
        bus.fifo_empty    = 1'b1;
        bus.fifo_data_out = 8'h00;
        bus.tx_ready      = 1'b1;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_data",  32'(bus.tx_data),  32'd0);
        chk("rst_sop",   32'(bus.tx_sop),   32'd0);
        chk("rst_eop",   32'(bus.tx_eop),   32'd0);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_rd",    32'(bus.fifo_rd_en), 32'd0);

        // T1: full 8-byte frame, tx_ready held high
        p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_bytes(p);
        run_until(8 + FRAME_OVERHEAD, 200, "t1");
        if (out_c.size() == 11) chk("t1_span", 32'(out_c[10] - out_c[0]), 32'd10);
        check_frame("t1", p);
        chk("t1_busy_end",  32'(bus.busy),     32'd0);
        chk("t1_valid_end", 32'(bus.tx_valid), 32'd0);

        // T2: short packet closed by idle timeout
        do_reset();
        p = '{8'h10, 8'h20, 8'h30};
        push_bytes(p);
        run_until(6, 100, "t2");
        check_frame("t2", p);

        // T3: full frame under tx_ready stalls
        do_reset();
        rdy_mode = 1;
        p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_bytes(p);
        run_until(11, 300, "t3");
        check_frame("t3", p);
        rdy_mode = 0;
        bus.tx_ready = 1'b1;
        step();

        // T4: 12 bytes -> max-length frame then a 4-byte timeout frame
        do_reset();
        p  = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
        p2 = '{8'h48, 8'h49, 8'h4A, 8'h4B};
        push_bytes(p);
        push_bytes(p2);
        run_until(18, 400, "t4");
        check_frame("t4a", p);
        check_frame("t4b", p2);

        // T5: reset while payload byte 3 is presented
        do_reset();
        p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_bytes(p);
        run_until(5, 200, "t5_pre");
        rst = 1'b1;
        rdy_mode = 2;
        bus.tx_ready = 1'b0;
        step();
        chk("t5_valid", 32'(bus.tx_valid), 32'd0);
        chk("t5_data",  32'(bus.tx_data),  32'd0);
        chk("t5_sop",   32'(bus.tx_sop),   32'd0);
        chk("t5_eop",   32'(bus.tx_eop),   32'd0);
        chk("t5_busy",  32'(bus.busy),     32'd0);
        rst = 1'b0;
        rdy_mode = 0;
        bus.tx_ready = 1'b1;
        fifo_q.delete();
        bus.fifo_empty = 1'b1;
        out_q.delete();
        out_c.delete();
        p = '{8'h77, 8'h88};
        push_bytes(p);
        run_until(5, 100, "t5");
        check_frame("t5", p);

        // T6: fifo permanently empty
        do_reset();
        saw_rd = 1'b0;
        saw_valid = 1'b0;
        saw_busy = 1'b0;
        repeat (50) step();
        chk("t6_rd",    32'(saw_rd),    32'd0);
        chk("t6_valid", 32'(saw_valid), 32'd0);
        chk("t6_busy",  32'(saw_busy),  32'd0);

        chk("rd_while_empty", 32'(rd_empty_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
